atm_account_arbiter: RTL and testbench

- Owns the single account balance register and shares it between two requesters: requester 0 is the front-panel FSM and requester 1 is the remote host/service port.
- Serialises read, deposit and withdraw transactions through a request/grant/ack handshake.
- Uses round-robin arbitration.
- Performs bounds-checked arithmetic and returns a status code and the updated balance to the served requester.

---
 rtl/atm_account_arbiter.sv | 174 +++++++++++++++++
 tb/tb_atm_account_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/atm_account_arbiter.sv
// Round-robin arbiter that shares one account balance register between the front panel (0)
// and the remote host (1), serialising bounds-checked read/deposit/withdraw transactions.
module atm_account_arbiter #(
  parameter int unsigned          BAL_W    = 16,
  parameter int unsigned          AMT_W    = 4,
  parameter logic [BAL_W-1:0]     INIT_BAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [1:0]       op0,
  input  logic [AMT_W-1:0] amt0,
  input  logic [1:0]       op1,
  input  logic [AMT_W-1:0] amt1,
  output logic [1:0]       gnt,
  output logic [1:0]       ack,
  output logic [1:0]       status,
  output logic [BAL_W-1:0] bal_out,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for a request; arbitration and grant happen on leaving
  // GRANT | winner holds gnt; its op/amt are captured on leaving
  // EXEC  | result computed; balance/status/ack update on leaving
  // RESP  | ack pulse for the winner; gnt/ack clear on leaving
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_DEP   = 2'b01;
  localparam logic [1:0] OP_WDR   = 2'b10;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_INSUF = 2'b01;
  localparam logic [1:0] ST_OVF   = 2'b10;
  localparam logic [1:0] ST_BADOP = 2'b11;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       status_q, status_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic             busy_q, busy_d;
  logic             rr_last_q, rr_last_d;
  logic             win_q, win_d;
  logic [1:0]       op_q, op_d;
  logic [AMT_W-1:0] amt_q, amt_d;

  logic             winner;
  logic [BAL_W-1:0] amt_bal;
  logic [BAL_W:0]   sum;
  logic [BAL_W-1:0] diff;

  // Single requester wins outright; on contention the one not served last wins.
  always_comb begin
    winner = 1'b0;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~rr_last_q;
      default: winner = 1'b0;
    endcase
  end

  // Overflow is detected in the carry bit, so no wrap can reach the balance.
  always_comb begin
    amt_bal = '0;
    amt_bal[AMT_W-1:0] = amt_q;
    sum  = {1'b0, bal_q} + {1'b0, amt_bal};
    diff = bal_q - amt_bal;
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ack_d     = ack_q;
    status_d  = status_q;
    bal_d     = bal_q;
    rr_last_d = rr_last_q;
    win_d     = win_q;
    op_d      = op_q;
    amt_d     = amt_q;

    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          win_d     = winner;
          rr_last_d = winner;
          gnt_d     = winner ? 2'b10 : 2'b01;
          state_d   = GRANT;
        end
      end
      GRANT: begin
        op_d    = win_q ? op1  : op0;
        amt_d   = win_q ? amt1 : amt0;
        state_d = EXEC;
      end
      EXEC: begin
        ack_d   = gnt_q;
        state_d = RESP;
        case (op_q)
          OP_READ: status_d = ST_OK;
          OP_DEP: begin
            if (sum[BAL_W]) begin
              status_d = ST_OVF;
            end else begin
              status_d = ST_OK;
              bal_d    = sum[BAL_W-1:0];
            end
          end
          OP_WDR: begin
            if (amt_bal > bal_q) begin
              status_d = ST_INSUF;
            end else begin
              status_d = ST_OK;
              bal_d    = diff;
            end
          end
          default: status_d = ST_BADOP;
        endcase
      end
      RESP: begin
        ack_d   = 2'b00;
        gnt_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 2'b00;
        ack_d   = 2'b00;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 2'b00;
      ack_q     <= 2'b00;
      status_q  <= ST_OK;
      bal_q     <= INIT_BAL;
      busy_q    <= 1'b0;
      rr_last_q <= 1'b1;
      win_q     <= 1'b0;
      op_q      <= OP_READ;
      amt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ack_q     <= ack_d;
      status_q  <= status_d;
      bal_q     <= bal_d;
      busy_q    <= busy_d;
      rr_last_q <= rr_last_d;
      win_q     <= win_d;
      op_q      <= op_d;
      amt_q     <= amt_d;
    end
  end

  assign gnt     = gnt_q;
  assign ack     = ack_q;
  assign status  = status_q;
  assign bal_out = bal_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed bench for atm_account_arbiter: handshake timing, round-robin order,
// bounds-checked arithmetic, mid-transaction reset and operand capture.
module tb_atm_account_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  op0, op1;
  logic [3:0]  amt0, amt1;
  logic [1:0]  gnt, ack, status;
  logic [15:0] bal_out;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] OK = 2'b00, INSUF = 2'b01, OVF = 2'b10, BADOP = 2'b11;

  atm_account_arbiter #(.BAL_W(16), .AMT_W(4), .INIT_BAL(16'h0000)) dut (
    .clk(clk), .rst(rst), .req(req),
    .op0(op0), .amt0(amt0), .op1(op1), .amt1(amt1),
    .gnt(gnt), .ack(ack), .status(status), .bal_out(bal_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called #1 after an edge with the FSM in IDLE; returns #1 after the edge back to IDLE.
  task automatic txn(input int r, input logic [1:0] op, input logic [3:0] amt,
                     input logic [1:0] est, input logic [15:0] eb, input bit full);
    logic [1:0] oh;
    oh = (r == 0) ? 2'b01 : 2'b10;
    req = oh;
    if (r == 0) begin op0 = op; amt0 = amt; end
    else        begin op1 = op; amt1 = amt; end
    tick();
    if (full) begin chk("gnt_rise", gnt, oh); chk("busy_grant", busy, 1'b1); chk("ack_early", ack, 2'b00); end
    tick();
    if (full) chk("ack_exec", ack, 2'b00);
    tick();
    req = 2'b00;
    if (full) begin chk("ack_pulse", ack, oh); chk("status", status, est); chk("bal", bal_out, eb); end
    tick();
    if (full) begin chk("gnt_clr", gnt, 2'b00); chk("ack_clr", ack, 2'b00); chk("busy_idle", busy, 1'b0); end
  endtask

  initial begin
    logic [1:0]  exp_w [4];
    logic [15:0] exp_b [4];
    exp_w[0] = 2'b01; exp_w[1] = 2'b10; exp_w[2] = 2'b01; exp_w[3] = 2'b10;
    exp_b[0] = 16'h0003; exp_b[1] = 16'h0007; exp_b[2] = 16'h0007; exp_b[3] = 16'h0007;

    rst = 1'b1; req = 2'b00; op0 = 2'b00; op1 = 2'b00; amt0 = 4'd0; amt1 = 4'd0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_bal", bal_out, 16'h0000);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_ack", ack, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_status", status, OK);

    txn(0, 2'b01, 4'd5, OK, 16'h0005, 1'b1);

    rst = 1'b1; tick(); rst = 1'b0; tick();
    chk("rst2_bal", bal_out, 16'h0000);

    // Both requesters held continuously: grants must alternate 0,1,0,1.
    req = 2'b11; op0 = 2'b01; amt0 = 4'd3; op1 = 2'b01; amt1 = 4'd4;
    for (int t = 0; t < 4; t++) begin
      tick();
      chk("rr_gnt", gnt, exp_w[t]);
      tick();
      tick();
      chk("rr_ack", ack, exp_w[t]);
      chk("rr_bal", bal_out, exp_b[t]);
      chk("rr_status", status, OK);
      if (t == 1) begin op0 = 2'b00; op1 = 2'b00; end
      if (t == 3) req = 2'b00;
      tick();
    end
    chk("rr_idle", busy, 1'b0);

    txn(1, 2'b10, 4'd8, INSUF, 16'h0007, 1'b1);
    txn(0, 2'b10, 4'd7, OK,    16'h0000, 1'b1);
    txn(0, 2'b10, 4'd0, OK,    16'h0000, 1'b1);
    txn(1, 2'b11, 4'd3, BADOP, 16'h0000, 1'b1);
    txn(0, 2'b00, 4'd9, OK,    16'h0000, 1'b1);

    // Ramp to 0xFFFC: 4368*15 + 12.
    for (int k = 0; k < 4368; k++) txn(k % 2, 2'b01, 4'd15, OK, 16'h0000, 1'b0);
    txn(0, 2'b01, 4'd12, OK, 16'hFFFC, 1'b1);
    txn(1, 2'b01, 4'd3,  OK, 16'hFFFF, 1'b1);
    txn(0, 2'b01, 4'd1,  OVF, 16'hFFFF, 1'b1);
    txn(1, 2'b01, 4'd0,  OK, 16'hFFFF, 1'b1);

    // Reset while the deposit is in EXEC.
    req = 2'b01; op0 = 2'b01; amt0 = 4'd5;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("midrst_bal", bal_out, 16'h0000);
    chk("midrst_gnt", gnt, 2'b00);
    chk("midrst_busy", busy, 1'b0);
    tick();
    rst = 1'b0; req = 2'b00;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("midrst_noack", ack, 2'b00);
    end
    chk("midrst_bal_hold", bal_out, 16'h0000);

    // Operand change after capture must be ignored.
    req = 2'b01; op0 = 2'b01; amt0 = 4'd5;
    tick();
    tick();
    amt0 = 4'd9; op0 = 2'b10;
    tick();
    req = 2'b00;
    chk("cap_ack", ack, 2'b01);
    chk("cap_bal", bal_out, 16'h0005);
    chk("cap_status", status, OK);
    tick();
    chk("cap_idle", busy, 1'b0);
    tick();
    chk("status_hold", status, OK);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
